// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant plus encoded index,
// released on Done, request drop, enable loss or a MAX_HOLD-cycle hold timeout.
module enc_rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 En,
  input  logic [N-1:0]         Req,
  input  logic                 Done,
  output logic [N-1:0]         Gnt,
  output logic [$clog2(N)-1:0] Gnt_idx,
  output logic                 Gnt_vld,
  output logic                 Timeout
);

  localparam int IW = $clog2(N);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  // Handshake: a requester owns the resource while its Req bit is high and Gnt
  // shows it; Done is only meaningful while Gnt_vld=1 and ends the grant at the next edge.

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  gnt_idx_q, gnt_idx_d;
  logic           timeout_q, timeout_d;

  logic [IW-1:0]  sel;
  logic [IW-1:0]  scan_idx;
  logic           rel_done, rel_drop, rel_hold, rel_en, release_now;

  // Scan from ptr upward with wrap; descending loop so the nearest hit wins.
  always_comb begin
    sel      = '0;
    scan_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = ptr_q + IW'(i);
      if (Req[scan_idx]) sel = scan_idx;
    end
  end

  always_comb begin
    rel_done    = Done;
    rel_drop    = ~Req[gnt_idx_q];
    rel_hold    = (cnt_q == HOLD_LAST);
    rel_en      = ~En;
    release_now = rel_done | rel_drop | rel_hold | rel_en;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (En && (Req != '0)) begin
          state_d   = GRANT;
          gnt_d     = ONE << sel;
          gnt_idx_d = sel;
          cnt_d     = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = gnt_idx_q + IW'(1);
          cnt_d     = '0;
          // Timeout only flags a revocation nobody else asked for.
          timeout_d = rel_hold & ~rel_done & ~rel_drop & ~rel_en;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign Gnt     = gnt_q;
  assign Gnt_idx = gnt_idx_q;
  assign Gnt_vld = (state_q == GRANT);
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Directed bench for enc_rr_arbiter: reset, single grant, rotation, timeout,
// release precedence, enable gating and asynchronous reset mid-grant.
module tb_enc_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  enc_rr_arbiter #(.N(8), .MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .En      (en),
    .Req     (req),
    .Done    (done),
    .Gnt     (gnt),
    .Gnt_idx (gnt_idx),
    .Gnt_vld (gnt_vld),
    .Timeout (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                           input logic e_vld, input logic e_to);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".idx"},     32'(gnt_idx), 32'(e_idx));
    check({tag, ".vld"},     32'(gnt_vld), 32'(e_vld));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  initial begin
    logic [31:0] e;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // reset and idle
    step();
    step();
    check_out("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("idle%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // single request, Done release, next scan starts at 5
    req = 8'h10;
    step();
    check_out("single", 8'h10, 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    step();
    check_out("single_rel", 8'h00, 3'd4, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h11;
    step();
    check_out("scan_from5", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    check_out("scan_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;

    // rotation from reset with all requesting
    pulse_reset();
    req = 8'hFF;
    for (int j = 0; j < 9; j++) exp_q.push_back(32'(j % 8));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      step();
      check_out($sformatf("rot_idx%0d", e), 8'(8'h01 << e[2:0]), e[2:0], 1'b1, 1'b0);
      done = 1'b1;
      step();
      check_out($sformatf("rot_gap%0d", e), 8'h00, e[2:0], 1'b0, 1'b0);
      done = 1'b0;
    end

    // timeout: 16 cycles of grant, pulse on release, then requester 7
    pulse_reset();
    req = 8'h81;
    step();
    check_out("to0_first", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      check_out($sformatf("to0_hold%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    step();
    check_out("to0_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check_out("to7_first", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      check_out($sformatf("to7_hold%0d", i), 8'h80, 3'd7, 1'b1, 1'b0);
    end
    step();
    check_out("to7_pulse", 8'h00, 3'd7, 1'b0, 1'b1);

    // Done coinciding with the hold limit suppresses Timeout
    step();
    check_out("sim_first", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) step();
    check_out("sim_cycle16", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    check_out("sim_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;

    // drop of the owner's request releases and advances the pointer past it
    req = 8'h0C;
    step();
    check_out("drop_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    step();
    check_out("drop_hold", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h08;
    step();
    check_out("drop_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    req = 8'h0C;
    step();
    check_out("drop_next", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'hFF;
    step();
    check_out("drop_done", 8'h00, 3'd3, 1'b0, 1'b0);
    done = 1'b0;

    // enable gating
    step();
    check_out("en_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    step();
    check_out("en_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_out("en_off_rel", 8'h00, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("en_off%0d", i), 8'h00, 3'd4, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check_out("en_back", 8'h20, 3'd5, 1'b1, 1'b0);

    // asynchronous reset mid-grant, then first grant restarts from 0
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    check_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_rr_arbiter.md
Name: enc_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among 8 requesters. Requests arrive as an 8-bit vector. The arbiter holds a one-hot grant and its 3-bit encoded index until the owner releases it or a hold-timeout fires, then rotates priority. It sits in front of the 8x3 encoder datapath and guarantees that only one request line is ever presented active, so the no-priority encoder always sees a legal one-hot input.

Parameters:
N, 8, number of requesters (fixed at 8 for this release; Gnt_idx width 3)
MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 2..255

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
En  input  1  arbiter enable; 0 blocks new grants and releases the current one
Req  input  8  request vector, bit i = requester i
Done  input  1  owner completion strobe, qualified only while Gnt_vld=1
Gnt  output  8  one-hot grant, registered
Gnt_idx  output  3  binary index of current or most recent grant, registered
Gnt_vld  output  1  1 while a grant is held
Timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n=0.
- Reset values:
  - Gnt=8'h00, Gnt_idx=3'd0, Gnt_vld=0, Timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If En=1 and Req!=0, select the first set bit scanning ptr, ptr+1, ..., ptr+7, wrapping mod 8.
  - On the next edge: Gnt=one-hot(sel), Gnt_idx=sel, Gnt_vld=1, counter=0, go to GRANT.
  - Latency: Req sampled at edge k produces Gnt at edge k+1.
  - If En=0 or Req=0, stay in IDLE with Gnt=0. Gnt_idx keeps its last value.
- GRANT:
  - Each cycle in GRANT, counter increments.
  - Release conditions, evaluated at each edge (any one is sufficient):
    - (a) Done=1
    - (b) Req[Gnt_idx]=0
    - (c) counter==MAX_HOLD-1
    - (d) En=0
  - On release, at the next edge: Gnt=0, Gnt_vld=0, ptr=(Gnt_idx+1) mod 8, counter=0, go to IDLE.
  - Timeout=1 for exactly that one cycle only when (c) is the sole cause. If (a), (b) or (d) coincides with (c), Timeout stays 0.
  - Without a release condition, the grant is held and Gnt/Gnt_idx are stable.
- Maximum grant length is MAX_HOLD cycles of Gnt_vld=1.
- Requests that arrive or change during GRANT do not pre-empt the holder.
- Minimum one-cycle gap (Gnt_vld=0) between consecutive grants, including a re-grant to the same requester.
- Fairness: after releasing requester i, requester i has the lowest priority. Any continuously asserting requester is granted within 7 grants.
- Gnt is always 0 or exactly one-hot. Gnt_vld == |Gnt at all times.
- Reset mid-grant: outputs drop asynchronously to reset values and ptr returns to 0. The first grant after reset follows the same rules as after power-up.
- Req bits are assumed synchronous to clk. No internal synchronizers.

Test Plan:
- Reset/idle: rst_n=0, then 1 with Req=8'h00, En=1 -> Gnt=8'h00, Gnt_vld=0, Gnt_idx=0 for 10 cycles.
- Single request: Req=8'b0001_0000 at edge k -> at k+1 Gnt=8'h10, Gnt_idx=4, Gnt_vld=1. Pulse Done -> next edge Gnt=0. Next arbitration scans from index 5.
- Rotation: from reset, Req=8'hFF held, Done pulsed one cycle after each grant -> Gnt_idx sequence 0,1,2,...,7,0. Each grant separated by one Gnt_vld=0 cycle.
- Timeout: MAX_HOLD=16, Req=8'h81 held, no Done -> Gnt_idx=0 for exactly 16 cycles. Timeout=1 on the release cycle. After the one-cycle gap, Gnt_idx=7. Timeout pulses again 16 cycles later.
- Simultaneous/drop: at grant cycle 16 assert Done -> release with Timeout=0. Separately, drop Req[Gnt_idx] mid-grant -> release next edge, ptr advances past that index.
- Enable and async reset: deassert En mid-grant -> Gnt=0 next edge, no new grant while En=0, even with Req=8'hFF. Re-enable -> grant to (previous idx+1). Assert rst_n=0 mid-grant -> Gnt=0 without waiting for a clk edge.
